// File: rtl/pifo_sched.sv
// Sorted-array PIFO: single push/single pop, unsigned rank (lower wins), FIFO order among equal ranks.
// Latency: a push is visible at the head one cycle later; drop/drop_flow are registered. Optional PIFO_DROP_CNT_EN adds a drop counter.
// Backpressure: OVF_MODE=0 deasserts push_ready when full; OVF_MODE=1 always accepts and evicts the worst entry or discards the push.
module pifo_sched #(
    parameter int SIZE     = 16,
    parameter int RANK_W   = 16,
    parameter int VALUE_W  = 32,
    parameter int FLOWS    = 8,
    parameter int OVF_MODE = 0,
    localparam int FLOW_W  = (FLOWS > 1) ? $clog2(FLOWS) : 1,
    localparam int CNT_W   = $clog2(SIZE + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_valid,
    output logic               push_ready,
    input  logic [RANK_W-1:0]  push_rank,
    input  logic [VALUE_W-1:0] push_value,
    input  logic [FLOW_W-1:0]  push_flow,
    output logic               pop_valid,
    input  logic               pop_ready,
    output logic [RANK_W-1:0]  pop_rank,
    output logic [VALUE_W-1:0] pop_value,
    output logic [FLOW_W-1:0]  pop_flow,
    output logic [CNT_W-1:0]   count,
    output logic               drop,
    output logic [FLOW_W-1:0]  drop_flow
`ifdef PIFO_DROP_CNT_EN
    ,
    input  logic               drop_clr,
    output logic [31:0]        drop_count
`endif
);

    typedef struct packed {
        logic               vld;
        logic [RANK_W-1:0]  rank;
        logic [VALUE_W-1:0] value;
        logic [FLOW_W-1:0]  flow;
    } entry_t;

    entry_t ent  [SIZE];
    entry_t base [SIZE];
    entry_t below[SIZE];
    entry_t nxt  [SIZE];
    entry_t new_ent;

    logic              full;
    logic              pop_fire;
    logic              push_fire;
    logic              do_ins;
    logic              drop_nxt;
    logic [FLOW_W-1:0] drop_flow_nxt;
    logic [CNT_W-1:0]  count_nxt;
    int                ins_idx;

    assign full       = ent[SIZE-1].vld;
    assign push_ready = (OVF_MODE != 0) ? 1'b1 : !full;
    assign pop_valid  = ent[0].vld;
    assign pop_rank   = ent[0].rank;
    assign pop_value  = ent[0].value;
    assign pop_flow   = ent[0].flow;
    assign pop_fire   = pop_valid & pop_ready;
    assign push_fire  = push_valid & push_ready;
    assign new_ent    = '{vld: 1'b1, rank: push_rank, value: push_value, flow: push_flow};

    // Insert position is taken against the array as it will look after any pop.
    always_comb begin
        for (int i = 0; i < SIZE - 1; i++) begin
            base[i] = pop_fire ? ent[i+1] : ent[i];
        end
        base[SIZE-1] = pop_fire ? '0 : ent[SIZE-1];
        below[0] = '0;
        for (int i = 1; i < SIZE; i++) begin
            below[i] = base[i-1];
        end
        ins_idx = 0;
        for (int i = 0; i < SIZE; i++) begin
            if (base[i].vld && (base[i].rank <= push_rank)) begin
                ins_idx = ins_idx + 1;
            end
        end
    end

    always_comb begin
        do_ins        = 1'b0;
        drop_nxt      = 1'b0;
        drop_flow_nxt = drop_flow;
        count_nxt     = count;
        if (push_fire) begin
            if (full && !pop_fire) begin
                // Only reachable in push-out mode: evict the tail or discard the newcomer.
                drop_nxt = 1'b1;
                if (push_rank < ent[SIZE-1].rank) begin
                    do_ins        = 1'b1;
                    drop_flow_nxt = ent[SIZE-1].flow;
                end else begin
                    drop_flow_nxt = push_flow;
                end
            end else begin
                do_ins = 1'b1;
                if (!pop_fire) begin
                    count_nxt = count + 1'b1;
                end
            end
        end else if (pop_fire) begin
            count_nxt = count - 1'b1;
        end

        for (int i = 0; i < SIZE; i++) begin
            if (!do_ins) begin
                nxt[i] = base[i];
            end else if (i < ins_idx) begin
                nxt[i] = base[i];
            end else if (i == ins_idx) begin
                nxt[i] = new_ent;
            end else begin
                nxt[i] = below[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SIZE; i++) begin
                ent[i] <= '0;
            end
            count     <= '0;
            drop      <= 1'b0;
            drop_flow <= '0;
        end else begin
            ent       <= nxt;
            count     <= count_nxt;
            drop      <= drop_nxt;
            drop_flow <= drop_flow_nxt;
        end
    end

`ifdef PIFO_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop_clr) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 32'hFFFF_FFFF)) begin
            drop_count <= drop_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pifo_sched.sv
// Directed bench for pifo_sched: a drop-tail and a push-out instance (SIZE=4) driven with shared stimulus.
module tb_pifo_sched;

    localparam int SIZE    = 4;
    localparam int RANK_W  = 8;
    localparam int VALUE_W = 16;
    localparam int FLOW_W  = 3;
    localparam int CNT_W   = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               push_valid = 1'b0;
    logic [RANK_W-1:0]  push_rank = '0;
    logic [VALUE_W-1:0] push_value = '0;
    logic [FLOW_W-1:0]  push_flow = '0;
    logic               pop_ready = 1'b0;

    logic               push_ready_dt, push_ready_po;
    logic               pop_valid_dt, pop_valid_po;
    logic [RANK_W-1:0]  pop_rank_dt, pop_rank_po;
    logic [VALUE_W-1:0] pop_value_dt, pop_value_po;
    logic [FLOW_W-1:0]  pop_flow_dt, pop_flow_po;
    logic [CNT_W-1:0]   count_dt, count_po;
    logic               drop_dt, drop_po;
    logic [FLOW_W-1:0]  drop_flow_dt, drop_flow_po;
`ifdef PIFO_DROP_CNT_EN
    logic               drop_clr = 1'b0;
    logic [31:0]        drop_count_dt, drop_count_po;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pifo_sched #(.SIZE(SIZE), .RANK_W(RANK_W), .VALUE_W(VALUE_W), .FLOWS(8), .OVF_MODE(0)) dut_dt (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready_dt),
        .push_rank(push_rank), .push_value(push_value), .push_flow(push_flow),
        .pop_valid(pop_valid_dt), .pop_ready(pop_ready),
        .pop_rank(pop_rank_dt), .pop_value(pop_value_dt), .pop_flow(pop_flow_dt),
        .count(count_dt), .drop(drop_dt), .drop_flow(drop_flow_dt)
`ifdef PIFO_DROP_CNT_EN
        , .drop_clr(drop_clr), .drop_count(drop_count_dt)
`endif
    );

    pifo_sched #(.SIZE(SIZE), .RANK_W(RANK_W), .VALUE_W(VALUE_W), .FLOWS(8), .OVF_MODE(1)) dut_po (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready_po),
        .push_rank(push_rank), .push_value(push_value), .push_flow(push_flow),
        .pop_valid(pop_valid_po), .pop_ready(pop_ready),
        .pop_rank(pop_rank_po), .pop_value(pop_value_po), .pop_flow(pop_flow_po),
        .count(count_po), .drop(drop_po), .drop_flow(drop_flow_po)
`ifdef PIFO_DROP_CNT_EN
        , .drop_clr(drop_clr), .drop_count(drop_count_po)
`endif
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push1(input int rank, input int value, input int flow);
        push_valid = 1'b1;
        push_rank  = RANK_W'(rank);
        push_value = VALUE_W'(value);
        push_flow  = FLOW_W'(flow);
        tick();
        push_valid = 1'b0;
    endtask

    initial begin
        int exp_rank[4];
        int exp_po[4];

        // Reset state
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk_eq("rst_pop_valid", {pop_valid_dt, pop_valid_po}, 2'b00);
        chk_eq("rst_count_dt", count_dt, 0);
        chk_eq("rst_count_po", count_po, 0);
        chk_eq("rst_drop", {drop_dt, drop_po}, 2'b00);
        chk_eq("rst_push_ready", {push_ready_dt, push_ready_po}, 2'b11);

        // Sorting: ranks 7,3,5,1 pop out as 1,3,5,7
        push1(7, 7, 0); push1(3, 3, 0); push1(5, 5, 0); push1(1, 1, 0);
        chk_eq("sort_count_full", count_dt, 4);
        chk_eq("sort_ready_dt_full", push_ready_dt, 1'b0);
        chk_eq("sort_ready_po_full", push_ready_po, 1'b1);
        exp_rank = '{1, 3, 5, 7};
        pop_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk_eq("sort_pop_valid", pop_valid_dt, 1'b1);
            chk_eq("sort_pop_rank", pop_rank_dt, exp_rank[k]);
            chk_eq("sort_pop_rank_po", pop_rank_po, exp_rank[k]);
            chk_eq("sort_count", count_dt, 4 - k);
            tick();
        end
        pop_ready = 1'b0;
        chk_eq("sort_empty_valid", pop_valid_dt, 1'b0);
        chk_eq("sort_empty_count", count_po, 0);

        // Equal ranks dequeue in arrival order
        push1(2, 16'h0A, 1); push1(2, 16'h0B, 2); push1(2, 16'h0C, 3);
        pop_ready = 1'b1;
        chk_eq("tie_a", pop_value_dt, 16'h0A); tick();
        chk_eq("tie_b", pop_value_dt, 16'h0B); tick();
        chk_eq("tie_c", pop_value_dt, 16'h0C);
        chk_eq("tie_c_flow", pop_flow_dt, 3); tick();
        pop_ready = 1'b0;
        chk_eq("tie_empty", count_dt, 0);

        // Simultaneous push and pop against {1,4,9}
        push1(1, 1, 0); push1(4, 4, 0); push1(9, 9, 0);
        push_valid = 1'b1; push_rank = 8'd5; push_value = 16'd5; pop_ready = 1'b1;
        chk_eq("sim_head_before", pop_rank_dt, 1);
        tick();
        push_valid = 1'b0; pop_ready = 1'b0;
        chk_eq("sim_head_after", pop_rank_dt, 4);
        chk_eq("sim_count", count_dt, 3);
        chk_eq("sim_drop", {drop_dt, drop_po}, 2'b00);
        exp_rank = '{4, 5, 9, 0};
        pop_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk_eq("sim_drain", pop_rank_dt, exp_rank[k]);
            tick();
        end
        pop_ready = 1'b0;
        chk_eq("sim_drained", count_dt, 0);

        // Full {1,2,3,4}: drop-tail stalls, push-out evicts the tail three times
        do_reset();
        push1(1, 1, 1); push1(2, 2, 2); push1(3, 3, 3); push1(4, 4, 4);
        chk_eq("dt_ready_low", push_ready_dt, 1'b0);
        push_valid = 1'b1; push_rank = 8'd0; push_value = 16'd0; push_flow = 3'd5;
        exp_po = '{4, 3, 2, 0};
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_eq("dt_no_drop", drop_dt, 1'b0);
            chk_eq("dt_count", count_dt, 4);
            chk_eq("dt_head", pop_rank_dt, 1);
            chk_eq("po_drop", drop_po, 1'b1);
            chk_eq("po_drop_flow", drop_flow_po, exp_po[k]);
            chk_eq("po_count", count_po, 4);
        end
        push_valid = 1'b0;
        tick();
        chk_eq("ovf_drop_cleared", {drop_dt, drop_po}, 2'b00);
        exp_rank = '{1, 2, 3, 4};
        exp_po   = '{0, 0, 0, 1};
        pop_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk_eq("dt_drain", pop_rank_dt, exp_rank[k]);
            chk_eq("po_drain", pop_rank_po, exp_po[k]);
            tick();
        end
        pop_ready = 1'b0;

        // Push-out against {1,2,3,8}
        do_reset();
        push1(1, 1, 1); push1(2, 2, 2); push1(3, 3, 3); push1(8, 8, 7);
        push1(5, 5, 3);
        chk_eq("po_evict_drop", drop_po, 1'b1);
        chk_eq("po_evict_flow", drop_flow_po, 7);
        chk_eq("po_evict_count", count_po, 4);
        chk_eq("dt_stall_drop", drop_dt, 1'b0);
        tick();
        chk_eq("po_evict_pulse", drop_po, 1'b0);
        push1(9, 9, 6);
        chk_eq("po_discard_drop", drop_po, 1'b1);
        chk_eq("po_discard_flow", drop_flow_po, 6);
        tick();
        chk_eq("po_discard_pulse", drop_po, 1'b0);
`ifdef PIFO_DROP_CNT_EN
        chk_eq("po_drop_count", drop_count_po, 2);
        chk_eq("dt_drop_count", drop_count_dt, 0);
`endif
        exp_rank = '{1, 2, 3, 8};
        exp_po   = '{1, 2, 3, 5};
        pop_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk_eq("po_final_dt", pop_rank_dt, exp_rank[k]);
            chk_eq("po_final_po", pop_rank_po, exp_po[k]);
            tick();
        end
        pop_ready = 1'b0;
`ifdef PIFO_DROP_CNT_EN
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        chk_eq("drop_clr", drop_count_po, 0);
        push1(1, 1, 1); push1(2, 2, 2); push1(3, 3, 3); push1(4, 4, 4);
        push1(9, 9, 5);
        tick();
        chk_eq("drop_count_one", drop_count_po, 1);
        do_reset();
`endif

        // Asynchronous reset mid-run with a push pending
        push1(1, 1, 1); push1(2, 2, 2); push1(3, 3, 3);
        chk_eq("mid_count_pre", count_dt, 3);
        push_valid = 1'b1; push_rank = 8'd4;
        #2 rst = 1'b1;
        #1;
        chk_eq("mid_pop_valid", {pop_valid_dt, pop_valid_po}, 2'b00);
        chk_eq("mid_count", {count_dt, count_po}, 0);
        chk_eq("mid_drop", {drop_dt, drop_po}, 2'b00);
`ifdef PIFO_DROP_CNT_EN
        chk_eq("mid_drop_count", drop_count_po, 0);
`endif
        tick();
        push_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk_eq("mid_after_count", count_po, 0);
        chk_eq("mid_after_ready", {push_ready_dt, push_ready_po}, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pifo_sched.md
Name: pifo_sched

Overview:
- Parametrised single-push/single-pop PIFO, the next generation of the flow scheduler.
- Rank, value and flow-id widths are generic. Flow id is binary-encoded rather than one-hot.
- Handshakes are ready/valid. An occupancy count is exported.
- A selectable overflow policy chooses between drop-tail and push-out (evict worst rank). Sits between the classifier and the egress arbiter.

Parameters:
- SIZE, 16, number of entries; must be >= 2.
- RANK_W, 16, rank width; compared unsigned, lower rank = higher priority.
- VALUE_W, 32, payload width.
- FLOWS, 8, number of flows; FLOW_W = max(1, $clog2(FLOWS)).
- OVF_MODE, 0, overflow policy: 0 = drop-tail, 1 = push-out.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- push_valid  in  1  push request.
- push_ready  out  1  push accepted this cycle when high together with push_valid.
- push_rank  in  RANK_W  rank of pushed element.
- push_value  in  VALUE_W  payload of pushed element.
- push_flow  in  FLOW_W  flow id of pushed element.
- pop_valid  out  1  head entry present.
- pop_ready  in  1  consumer takes head when high together with pop_valid.
- pop_rank  out  RANK_W  head rank.
- pop_value  out  VALUE_W  head payload.
- pop_flow  out  FLOW_W  head flow id.
- count  out  $clog2(SIZE+1)  current occupancy.
- drop  out  1  one-cycle pulse: an element was discarded.
- drop_flow  out  FLOW_W  flow id of the discarded element; valid while drop=1.

Behaviour:
- Storage: SIZE-entry sorted register array, each entry {valid, rank, value, flow}.
  - Entry 0 is the head. Valid entries are contiguous from entry 0, and ranks are non-decreasing.
- Reset (async assert, sync-safe deassert): all valids = 0, count = 0, pop_valid = 0, drop = 0.
  - push_ready is 1 after reset. It is registered-state-derived only and never depends combinationally on push_valid.
- Pop outputs come straight from entry 0. pop_valid = valid[0].
  - pop_rank, pop_value and pop_flow are don't-care when pop_valid = 0.
- Pop fires when pop_valid & pop_ready. Entries shift down one at the next clock edge, and valid[SIZE-1] clears.
- Push fires when push_valid & push_ready. The element is written into the array at the next clock edge.
  - Latency 1: a push in cycle N is visible at the head no earlier than cycle N+1.
  - There is no same-cycle bypass to the pop outputs.
- Insert index = number of valid entries with rank <= push_rank.
  - Equal ranks therefore dequeue in arrival order (FIFO tie-break).
  - Entries at and above the insert index shift up one.
- Simultaneous push and pop:
  - The index is computed against the post-pop view (entries 1..SIZE-1).
  - Net shift is computed per entry and count is unchanged.
  - Never a drop, even when full.
- Push with an empty queue and pop_ready high: the pop is ignored (pop_valid = 0). The push proceeds normally.
- Full (count == SIZE), push, no pop, OVF_MODE = 0:
  - push_ready = !full, so the push stalls and nothing is dropped.
- Full, push, no pop, OVF_MODE = 1:
  - push_ready is always 1.
  - If push_rank < rank[SIZE-1]: the tail is evicted and the new element is inserted. drop = 1 and drop_flow = the evicted tail's flow, in the next cycle.
  - Otherwise the new element is discarded. drop = 1 and drop_flow = push_flow, in the next cycle.
  - count stays at SIZE in both cases.
- drop and drop_flow are registered, high for exactly one cycle per event.
- count: +1 on push only, −1 on pop only, unchanged on both or on push-out; saturates within 0..SIZE by construction.
- Reset mid-operation clears all state immediately. No partially applied shift survives.

Optional Feature:
- Macro: PIFO_DROP_CNT_EN.
- When defined:
  - Adds output drop_count [31:0], which increments on every drop pulse and saturates at 32'hFFFF_FFFF.
  - Adds input drop_clr [0:0], which zeroes the counter synchronously. If drop_clr and drop coincide, the counter reads 0 afterwards.
  - Reset clears drop_count.
- When undefined: neither port exists, and there is no counter logic.

Test Plan:
- Sorting: SIZE=4. Push ranks 7,3,5,1 on consecutive cycles, then pop continuously → pop_rank sequence 1,3,5,7; count 4→0; pop_valid falls after the 4th pop.
- Tie order: push (rank 2, value A), then (2, B), then (2, C) → pops return A, B, C in that order.
- Simultaneous push/pop: queue {1,4,9}. Same cycle pop + push rank 5 → next cycle head = 4, contents {4,5,9}, count stays 3.
- Drop-tail: OVF_MODE=0, SIZE=4, queue full {1,2,3,4} → push_ready = 0; push of rank 0 held 3 cycles produces no state change and drop = 0.
- Push-out: OVF_MODE=1, full {1,2,3,8}. Push rank 5 flow 3 → contents {1,2,3,5}; drop pulses 1 cycle with drop_flow = flow of the rank-8 entry. Then push rank 9 flow 6 → contents unchanged; drop = 1 with drop_flow = 6.
- Reset mid-run: assert rst asynchronously while count = 3 and push_valid = 1 → pop_valid, count and drop go to 0 immediately. With PIFO_DROP_CNT_EN, drop_count = 0.
